sargantana_icache_way_alloc: RTL
================================

Name: sargantana_icache_way_alloc

Overview:
- Victim-way allocation controller for the instruction cache miss path.
- On a refill request for a set, picks the way to fill: the lowest-index invalid way, otherwise the tree-PLRU victim.
- Offers the victim to the refill engine with a valid/ready handshake and holds the choice until the refill commits.
- Keeps per-set tree-PLRU state, updated by lookup hits and by refill commits.

Parameters:
- ICACHE_N_WAY, 4, number of ways; power of two, >= 2. Sets the PLRU tree size (N_WAY-1 bits per set).
- ICACHE_N_SETS, 64, number of sets; power of two. SET_W = $clog2(ICACHE_N_SETS), WAY_W = $clog2(ICACHE_N_WAY).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  clear all PLRU state and abort any allocation
- hit_valid_i  in  1  lookup hit; update PLRU
- hit_set_i  in  SET_W  set index of the hit
- hit_way_i  in  N_WAY  one-hot hit way
- req_valid_i  in  1  allocation request
- req_ready_o  out  1  controller idle, request accepted
- req_set_i  in  SET_W  set to allocate into
- req_valid_ways_i  in  N_WAY  valid bits of that set
- vic_valid_o  out  1  victim offered
- vic_ready_i  in  1  refill engine takes the victim
- vic_way_o  out  WAY_W  victim way index
- vic_oh_o  out  N_WAY  victim way, one-hot
- vic_invalid_o  out  1  victim was an invalid way
- commit_i  in  1  refill of the victim is complete
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async): FSM = IDLE, all PLRU bits 0, captured set/way registers 0. Outputs: req_ready_o=1, vic_valid_o=0, vic_way_o=0, vic_oh_o=0, vic_invalid_o=0, busy_o=0.
- FSM states: IDLE, SELECT, OFFER, REFILL.
  - IDLE: req_ready_o=1. On req_valid_i: capture req_set_i and req_valid_ways_i, go to SELECT.
  - SELECT (1 cycle): compute the victim from the PLRU bits of the captured set as registered this cycle, so hits from earlier cycles are included. Register the victim and go to OFFER.
  - OFFER: vic_valid_o=1; vic_way_o, vic_oh_o and vic_invalid_o are stable. On vic_ready_i go to REFILL.
  - REFILL: wait for commit_i. On commit, mark the victim MRU in its set and go to IDLE.
- Latency: request accepted at cycle T, vic_valid_o=1 at T+2. The next request can be accepted the cycle after commit.
- Victim selection:
  - If ~req_valid_ways_i != 0: victim = lowest set bit of ~valid (trailing-zero priority), vic_invalid_o=1.
  - Otherwise the tree-PLRU walk selects the victim, vic_invalid_o=0.
- PLRU tree (N_WAY=4): bits b0, b1, b2.
  - Victim: b0=0 gives {0,b1}; b0=1 gives {1,b2}.
  - Touching way w: b0 = ~w[1]. If w[1]=0 then b1 = ~w[0], else b2 = ~w[0].
  - Larger N_WAY generalises as a heap-ordered tree, root = bit 0.
- hit_way_i handling: multi-hot uses the lowest set bit; all-zero means no update.
- Hits are accepted in every state, including on the set being allocated.
- Simultaneous hit and commit:
  - Different sets: both updates are applied.
  - Same set: apply the hit touch first, then the commit touch; commit wins on any shared bits.
- commit_i outside REFILL is ignored. vic_ready_i outside OFFER is ignored.
- flush_i has priority over everything. Next cycle: FSM = IDLE, all PLRU bits 0, vic_valid_o=0. A hit or commit in the same cycle as flush_i is dropped.
- Reset mid-operation: same effect as flush, applied asynchronously.

Optional Feature:
- Macro: ICACHE_WAY_ALLOC_RANDOM_EN.
- Defined:
  - PLRU storage is removed and hits are ignored.
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) with reset seed 8'h01 advances every cycle.
  - The all-valid victim is lfsr[WAY_W-1:0], sampled in SELECT.
  - Invalid-way priority is unchanged.
- Undefined: tree-PLRU as specified above.

Test Plan:
- Reset, then request set 5 with valid=4'b1111 -> vic_valid_o at T+2, vic_way_o=0, vic_oh_o=4'b0001, vic_invalid_o=0.
- Request set 9 with valid=4'b1011 -> vic_way_o=2, vic_invalid_o=1; PLRU bits of set 9 unchanged until commit.
- Hits on set 3, way 0 then way 2; request set 3 all-valid -> vic_way_o=1. Commit -> a new request on set 3 gives vic_way_o=3.
- Hold vic_ready_i=0 for 5 cycles in OFFER -> vic_way_o/vic_oh_o stable, req_ready_o=0, busy_o=1. Extra req_valid_i pulses are not accepted.
- flush_i in REFILL after hits on set 3 -> next cycle req_ready_o=1, vic_valid_o=0. Request on set 3 all-valid gives vic_way_o=0. A late commit_i is ignored.
- Same cycle on set 7: hit way 2 and commit way 1 -> b0=1, b1=0, b2=1; a following all-valid request gives vic_way_o=3.

Source files
------------

// File: rtl/sargantana_icache_way_alloc.sv
// Victim-way allocation for the I-cache miss path: lowest invalid way, else tree-PLRU victim.
// Define ICACHE_WAY_ALLOC_RANDOM_EN to replace the PLRU with an 8-bit LFSR random victim.
module sargantana_icache_way_alloc #(
    parameter int ICACHE_N_WAY  = 4,
    parameter int ICACHE_N_SETS = 64,
    localparam int SET_W = $clog2(ICACHE_N_SETS),
    localparam int WAY_W = $clog2(ICACHE_N_WAY)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    hit_valid_i,
    input  logic [SET_W-1:0]        hit_set_i,
    input  logic [ICACHE_N_WAY-1:0] hit_way_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [SET_W-1:0]        req_set_i,
    input  logic [ICACHE_N_WAY-1:0] req_valid_ways_i,
    output logic                    vic_valid_o,
    input  logic                    vic_ready_i,
    output logic [WAY_W-1:0]        vic_way_o,
    output logic [ICACHE_N_WAY-1:0] vic_oh_o,
    output logic                    vic_invalid_o,
    input  logic                    commit_i,
    output logic                    busy_o
);
    localparam int N = ICACHE_N_WAY;

    typedef enum logic [1:0] {IDLE, SELECT, OFFER, REFILL} state_e;
    state_e state_q, state_d;

    logic [SET_W-1:0] cap_set_q;
    logic [N-1:0]     cap_valid_q;
    logic [WAY_W-1:0] vic_way_q;
    logic [N-1:0]     vic_oh_q;
    logic             vic_inv_q;
    logic [WAY_W-1:0] all_valid_way;
    logic [WAY_W-1:0] sel_way;

    function automatic logic [WAY_W-1:0] lowest_idx(input logic [N-1:0] v);
        lowest_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = WAY_W'(i);
        end
    endfunction

`ifdef ICACHE_WAY_ALLOC_RANDOM_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= 8'h01;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign all_valid_way = lfsr_q[WAY_W-1:0];
`else
    // Heap-ordered tree: node k has children 2k+1 (upper half 0) and 2k+2 (upper half 1).
    function automatic logic [N-2:0] plru_touch(input logic [N-2:0] row, input logic [WAY_W-1:0] way);
        int   node;
        logic b;
        node = 0;
        plru_touch = row;
        for (int l = 0; l < WAY_W; l++) begin
            b = way[WAY_W-1-l];
            plru_touch[node] = ~b;
            node = 2 * node + 1 + int'(b);
        end
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [N-2:0] row);
        int   node;
        logic b;
        node = 0;
        plru_victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = row[node];
            plru_victim[WAY_W-1-l] = b;
            node = 2 * node + 1 + int'(b);
        end
    endfunction

    logic [N-2:0] plru_q [ICACHE_N_SETS];
    logic         hit_en, commit_en;
    logic [N-2:0] hit_row, commit_base, commit_row;

    assign hit_en      = hit_valid_i && (|hit_way_i) && !flush_i;
    assign commit_en   = (state_q == REFILL) && commit_i && !flush_i;
    assign hit_row     = plru_touch(plru_q[hit_set_i], lowest_idx(hit_way_i));
    // Same-set hit and commit: the commit touch is layered on top of the hit touch.
    assign commit_base = (hit_en && hit_set_i == cap_set_q) ? hit_row : plru_q[cap_set_q];
    assign commit_row  = plru_touch(commit_base, vic_way_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < ICACHE_N_SETS; s++) plru_q[s] <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < ICACHE_N_SETS; s++) plru_q[s] <= '0;
        end else begin
            if (hit_en)    plru_q[hit_set_i] <= hit_row;
            if (commit_en) plru_q[cap_set_q] <= commit_row;
        end
    end

    assign all_valid_way = plru_victim(plru_q[cap_set_q]);
`endif

    assign sel_way = (|(~cap_valid_q)) ? lowest_idx(~cap_valid_q) : all_valid_way;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // vic_valid_o stays high with a stable victim until vic_ready_i is seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = SELECT;
            SELECT:  state_d = OFFER;
            OFFER:   if (vic_ready_i) state_d = REFILL;
            REFILL:  if (commit_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_set_q   <= '0;
            cap_valid_q <= '0;
            vic_way_q   <= '0;
            vic_oh_q    <= '0;
            vic_inv_q   <= 1'b0;
        end else if (flush_i) begin
            cap_set_q   <= '0;
            cap_valid_q <= '0;
            vic_way_q   <= '0;
            vic_oh_q    <= '0;
            vic_inv_q   <= 1'b0;
        end else if (state_q == IDLE && req_valid_i) begin
            cap_set_q   <= req_set_i;
            cap_valid_q <= req_valid_ways_i;
        end else if (state_q == SELECT) begin
            vic_way_q   <= sel_way;
            vic_oh_q    <= {{(N-1){1'b0}}, 1'b1} << sel_way;
            vic_inv_q   <= |(~cap_valid_q);
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign vic_valid_o   = (state_q == OFFER);
    assign busy_o        = (state_q != IDLE);
    assign vic_way_o     = vic_way_q;
    assign vic_oh_o      = vic_oh_q;
    assign vic_invalid_o = vic_inv_q;
endmodule
